usb_rx_fsm: RTL
===============

# usb_rx_fsm

Receive-side packet controller for the USB full-speed endpoint, the counterpart of the transmit FSM on the same bus. It consumes bytes from the receive shift register and bit timer, checks SYNC, PID, CRC16 and EOP framing, and decodes the packet type. Data payload goes to the shared data buffer through a two-byte holdback pipeline, so the trailing CRC bytes are never written.

## Interface
- MAX_PAYLOAD, 64, maximum payload bytes accepted in one DATA packet
- clk  in  1  system clock
- n_rst  in  1  asynchronous, active-low reset
- d_edge  in  1  1-cycle pulse on any transition of synchronized D+
- eop  in  1  level, high while line is sampled SE0
- byte_received  in  1  1-cycle pulse; rcv_data valid this cycle
- rcv_data  in  8  assembled byte, same bit order the transmitter loads
- buffer_full  in  1  data buffer cannot accept a write
- rcving  out  1  packet in progress; also enables the bit timer
- w_enable  out  1  1-cycle buffer write strobe
- rx_data  out  8  payload byte, valid with w_enable
- rx_packet  out  3  0 none, 1 DATA, 2 ACK, 3 NAK, 4 OUT, 5 IN
- rx_data_ready  out  1  1-cycle pulse: DATA packet accepted
- rx_transfer_active  out  1  DATA PID accepted, packet not yet closed
- r_error  out  1  sticky receive error
- rx_byte_count  out  7  payload bytes written this packet

## Operation
- Reset value: state IDLE; all outputs 0; holdback empty.
- IDLE: d_edge -> SYNC_WAIT. rcving=1. r_error, rx_packet and rx_byte_count are cleared. CRC is cleared.
- SYNC_WAIT: on byte_received, rcv_data==SYNC_BYTE -> PID_WAIT; any other byte -> ERR.
- PID_WAIT: byte_received with a legal PID -> rx_packet is set next cycle, then:
  - PID_DATA -> DATA; rx_transfer_active=1.
  - PID_OUT/PID_IN -> TOKEN; token byte count is reset.
  - PID_ACK/PID_NAK -> HS.
- PID_WAIT, illegal PID -> ERR.
- DATA: each byte_received feeds the CRC checker and the holdback (hold0, hold1, cnt 0..2).
  - cnt==2: hold1 is emitted (w_enable=1, rx_data=hold1), rx_byte_count increments, then the holdback shifts.
  - buffer_full or rx_byte_count==MAX_PAYLOAD at write time -> ERR; no write occurs.
- DATA, eop: cnt==2 and crc_ok -> EOP_WAIT with rx_data_ready pulse; otherwise -> ERR. The held CRC bytes are discarded.
- TOKEN: exactly 2 bytes (addr/endp, CRC5; CRC5 is not checked), then eop -> EOP_WAIT. eop with count≠2, or a third byte -> ERR.
- HS: eop -> EOP_WAIT; byte_received -> ERR.
- eop inside SYNC_WAIT or PID_WAIT -> ERR.
- ERR: r_error=1, rx_transfer_active=0, no writes. Waits for eop high then low -> IDLE.
- EOP_WAIT: eop low -> IDLE; rcving=0, rx_transfer_active=0.
- rx_packet and r_error hold until the next packet start.

## Timing
- All outputs registered; w_enable/rx_data assert the cycle after the byte_received that completes cnt==2.
- Payload byte k is written one cycle after byte k+2 arrives.
- rx_data_ready asserts 1 cycle after eop is first seen high in DATA.
- rx_packet updates 1 cycle after the PID byte_received.
- eop and byte_received in the same cycle: eop wins; the byte is ignored (not CRC-fed, not written).
- d_edge outside IDLE is ignored.
- Reset mid-packet: immediate return to IDLE; all outputs 0; the pending write is dropped.
- Zero-length DATA packet (PID + 2 CRC bytes) is legal: no writes, rx_data_ready pulses.

## Structure
- Shared package usb_pkg, used by TX and RX:
  - SYNC_BYTE 8'h80, PID_DATA 8'h3C, PID_ACK 8'h2D, PID_NAK 8'hA5, PID_OUT 8'h1E, PID_IN 8'h96.
  - rx_packet code enum; CRC16_RESIDUAL 16'hB001.
- Sub-module usb_crc16_chk: byte-wise reflected CRC16.
  - Polynomial 16'hA001, init 16'hFFFF.
  - Ports: clear and enable strobes, 8-bit data.
  - Output crc_ok = (crc==CRC16_RESIDUAL).
- FSM and holdback live in usb_rx_fsm.

## Test plan
- SYNC, DATA PID, bytes 8'h01 8'h02 8'h03, valid CRC, EOP -> 3 writes 01,02,03 in order. rx_byte_count=3, one rx_data_ready, rx_packet=1, r_error=0.
- Same packet with one CRC bit flipped -> 3 writes occur, no rx_data_ready, r_error=1 held until next d_edge in IDLE.
- SYNC, ACK 8'h2D, EOP -> rx_packet=2, no writes. A following NAK 8'hA5 packet -> rx_packet=3.
- Bad SYNC byte 8'h81 -> ERR, r_error=1, rcving drops only after eop falls.
- buffer_full raised before the 2nd payload write -> 1 write only, then r_error=1.
- OUT token with 3 bytes, and reset asserted mid-DATA -> r_error=1 for the token; after reset all outputs 0 and no w_enable.

Source files
------------

// File: rtl/usb_pkg.sv
// usb_pkg: constants, packet codes and CRC16 helpers shared by the USB TX and RX controllers.
package usb_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'h80;
  localparam logic [7:0] PID_DATA = 8'h3C;
  localparam logic [7:0] PID_ACK = 8'h2D;
  localparam logic [7:0] PID_NAK = 8'hA5;
  localparam logic [7:0] PID_OUT = 8'h1E;
  localparam logic [7:0] PID_IN = 8'h96;
  localparam logic [15:0] CRC16_POLY = 16'hA001;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;
  typedef enum logic [2:0] {PKT_NONE, PKT_DATA, PKT_ACK, PKT_NAK, PKT_OUT, PKT_IN} rx_pkt_e;
  typedef enum logic [3:0] {
    ST_IDLE, ST_SYNC_WAIT, ST_PID_WAIT, ST_DATA, ST_TOKEN, ST_HS, ST_ERR, ST_ERR_EOP, ST_EOP_WAIT
  } rx_state_e;
  function automatic rx_pkt_e pid_to_pkt(input logic [7:0] pid);
    return pid == PID_DATA ? PKT_DATA : pid == PID_ACK ? PKT_ACK : pid == PID_NAK ? PKT_NAK :
           pid == PID_OUT ? PKT_OUT : pid == PID_IN ? PKT_IN : PKT_NONE;
  endfunction
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc ^ {8'h00, d};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC16_POLY : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/usb_crc16_chk.sv
// usb_crc16_chk: byte-wise reflected CRC16 accumulator; crc_ok once data plus its CRC has been fed.
module usb_crc16_chk
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       crc_ok
);
  logic [15:0] r_crc;
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_crc <= CRC16_INIT;
    else if (clear) r_crc <= CRC16_INIT;
    else if (enable) r_crc <= crc16_byte(r_crc, data);
  assign crc_ok = r_crc == CRC16_RESIDUAL;
endmodule

// File: rtl/usb_rx_fsm.sv
// usb_rx_fsm: USB full-speed receive controller; frames SYNC/PID/CRC16/EOP and writes payload
// through a two-byte holdback so the trailing CRC bytes never reach the buffer.
module usb_rx_fsm
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_edge,
  input  logic       eop,
  input  logic       byte_received,
  input  logic [7:0] rcv_data,
  input  logic       buffer_full,
  output logic       rcving,
  output logic       w_enable,
  output logic [7:0] rx_data,
  output logic [2:0] rx_packet,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       r_error,
  output logic [6:0] rx_byte_count
);
  rx_state_e   r_state;
  logic [7:0]  r_hold0, r_hold1;
  logic [1:0]  r_cnt;
  logic        w_crc_ok, w_byte, w_fail, w_full;
  rx_pkt_e     w_pid;
  assign w_byte = byte_received && !eop;
  assign w_pid = pid_to_pkt(rcv_data);
  assign w_full = buffer_full || rx_byte_count == 7'(MAX_PAYLOAD);
  usb_crc16_chk u_crc (
    .clk(clk), .n_rst(n_rst), .clear(r_state == ST_IDLE && d_edge),
    .enable(r_state == ST_DATA && w_byte), .data(rcv_data), .crc_ok(w_crc_ok)
  );
  // every path into ERR is collected here; eop always outranks a same-cycle byte
  always_comb begin
    w_fail = 1'b0;
    case (r_state)
      ST_SYNC_WAIT: w_fail = eop || (byte_received && rcv_data != SYNC_BYTE);
      ST_PID_WAIT:  w_fail = eop || (byte_received && w_pid == PKT_NONE);
      ST_DATA:      w_fail = eop ? !(r_cnt == 2'd2 && w_crc_ok) : w_byte && r_cnt == 2'd2 && w_full;
      ST_TOKEN:     w_fail = eop ? r_cnt != 2'd2 : byte_received && r_cnt == 2'd2;
      ST_HS:        w_fail = w_byte;
      default:      w_fail = 1'b0;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= ST_IDLE;
      r_hold0 <= '0;
      r_hold1 <= '0;
      r_cnt <= '0;
      rcving <= 1'b0;
      w_enable <= 1'b0;
      rx_data <= '0;
      rx_packet <= '0;
      rx_data_ready <= 1'b0;
      rx_transfer_active <= 1'b0;
      r_error <= 1'b0;
      rx_byte_count <= '0;
    end else begin
      w_enable <= 1'b0;
      rx_data_ready <= 1'b0;
      if (w_fail) begin
        r_state <= ST_ERR;
        r_error <= 1'b1;
        rx_transfer_active <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: if (d_edge) begin
            r_state <= ST_SYNC_WAIT;
            rcving <= 1'b1;
            r_error <= 1'b0;
            rx_packet <= '0;
            rx_byte_count <= '0;
          end
          ST_SYNC_WAIT: if (byte_received) r_state <= ST_PID_WAIT;
          ST_PID_WAIT: if (byte_received) begin
            rx_packet <= w_pid;
            rx_transfer_active <= w_pid == PKT_DATA;
            r_cnt <= '0;
            r_state <= w_pid == PKT_DATA ? ST_DATA : (w_pid == PKT_OUT || w_pid == PKT_IN) ? ST_TOKEN : ST_HS;
          end
          ST_DATA: if (eop) begin
            r_state <= ST_EOP_WAIT;
            rx_data_ready <= 1'b1;
          end else if (byte_received) begin
            if (r_cnt == 2'd2) begin
              w_enable <= 1'b1;
              rx_data <= r_hold1;
              rx_byte_count <= rx_byte_count + 7'd1;
            end else r_cnt <= r_cnt + 2'd1;
            r_hold1 <= r_hold0;
            r_hold0 <= rcv_data;
          end
          ST_TOKEN: if (eop) r_state <= ST_EOP_WAIT;
                    else if (byte_received) r_cnt <= r_cnt + 2'd1;
          ST_HS: if (eop) r_state <= ST_EOP_WAIT;
          ST_ERR: if (eop) r_state <= ST_ERR_EOP;
          ST_ERR_EOP: if (!eop) begin
            r_state <= ST_IDLE;
            rcving <= 1'b0;
          end
          ST_EOP_WAIT: if (!eop) begin
            r_state <= ST_IDLE;
            rcving <= 1'b0;
            rx_transfer_active <= 1'b0;
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
